// File: rtl/msb_first_word_serializer.sv
// Parallel-to-serial word feeder: accepts a WIDTH-bit word over valid/ready and
// emits it MSB first with first/last framing, chaining words without a bubble.
module msb_first_word_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  input  logic             down_ready,
  output logic             bit_valid,
  output logic             new_bit,
  output logic             first_bit,
  output logic             last_bit,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;
  logic             xfer;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: shift on each transfer, reload on accept (also on the last bit)
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = up_data;
          cnt_d   = CW'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (cnt_q != '0) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - CW'(1);
          end else if (accept) begin
            shreg_d = up_data;
            cnt_d   = CW'(WIDTH - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the registered state; only up_ready looks at down_ready
  always_comb begin
    bit_valid = (state_q == SHIFT);
    busy      = (state_q == SHIFT);
    new_bit   = (state_q == SHIFT) && shreg_q[WIDTH-1];
    first_bit = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
    last_bit  = (state_q == SHIFT) && (cnt_q == '0);
    up_ready  = (state_q == IDLE) || (last_bit && down_ready);
    accept    = up_valid && up_ready;
    xfer      = bit_valid && down_ready;
  end

endmodule

// File: tb/tb_msb_first_word_serializer.sv
// Bench for msb_first_word_serializer: directed scenarios plus random traffic,
// checked every cycle against a queue of expected framed bits.
module tb_msb_first_word_serializer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         up_valid;
  logic [W-1:0] up_data;
  logic         up_ready;
  logic         down_ready;
  logic         bit_valid;
  logic         new_bit;
  logic         first_bit;
  logic         last_bit;
  logic         busy;

  int n_checks;
  int n_errors;

  // Each entry is {bit, first, last}; the front is what should be on the wire now
  logic [2:0] exp_q[$];
  bit         last_acc;
  int         res;
  int         res_last;

  msb_first_word_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_valid  (up_valid),
    .up_data   (up_data),
    .up_ready  (up_ready),
    .down_ready(down_ready),
    .bit_valid (bit_valid),
    .new_bit   (new_bit),
    .first_bit (first_bit),
    .last_bit  (last_bit),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [5:0] dut_outs();
    return {bit_valid, busy, up_ready, new_bit, first_bit, last_bit};
  endfunction

  function automatic logic [5:0] model_outs();
    if (exp_q.size() == 0) return 6'b001000;
    return {1'b1, 1'b1, exp_q[0][0] & down_ready, exp_q[0][2], exp_q[0][1], exp_q[0][0]};
  endfunction

  // One clock: check at negedge, advance the model at posedge, return #1 later
  task automatic step(input string tag);
    bit acc, xf;
    @(negedge clk);
    check(tag, 32'(dut_outs()), 32'(model_outs()));
    acc = up_valid && ((exp_q.size() == 0) || (exp_q[0][0] && down_ready));
    xf  = (exp_q.size() != 0) && down_ready;
    if (bit_valid && down_ready) begin
      if (first_bit) res = 0;
      res = (2 * res + int'(new_bit)) % 5;
      if (last_bit) res_last = res;
    end
    @(posedge clk);
    if (xf) void'(exp_q.pop_front());
    if (acc) begin
      for (int i = W - 1; i >= 0; i--)
        exp_q.push_back({up_data[i], 1'(i == W - 1), 1'(i == 0)});
    end
    last_acc = acc;
    #1;
  endtask

  task automatic offer_until_taken(input string tag, input logic [W-1:0] d);
    bit taken;
    up_valid = 1'b1;
    up_data  = d;
    taken    = 1'b0;
    for (int k = 0; k < 40 && !taken; k++) begin
      step(tag);
      taken = last_acc;
    end
    check({tag, "_accepted"}, 32'(taken), 32'd1);
    up_valid = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    res        = 0;
    res_last   = -1;
    last_acc   = 1'b0;
    rst        = 1'b0;
    up_valid   = 1'b0;
    up_data    = '0;
    down_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_outs", 32'(dut_outs()), 32'h08);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Idle stability with down_ready toggling
    for (int k = 0; k < 20; k++) begin
      down_ready = 1'($urandom_range(0, 1));
      step("idle");
    end

    // Single word, also run through a divide-by-5 residue
    down_ready = 1'b1;
    offer_until_taken("t1", 8'hB4);
    repeat (9) step("t1_bits");
    check("t1_div5", 32'(res_last), 32'(180 % 5));

    // Back-to-back: second word offered while first is shifting
    offer_until_taken("t2a", 8'h0F);
    offer_until_taken("t2b", 8'hF0);
    check("t2_no_bubble", 32'(exp_q.size()), 32'(W));
    repeat (9) step("t2_bits");

    // Backpressure on bit 5 of A5
    offer_until_taken("t3", 8'hA5);
    repeat (2) step("t3_bits");
    down_ready = 1'b0;
    repeat (3) step("t3_stall");
    down_ready = 1'b1;
    repeat (7) step("t3_bits");

    // Busy rejection: offered mid-word, taken on the last-bit cycle only
    offer_until_taken("t4a", 8'h3C);
    repeat (3) step("t4_bits");
    offer_until_taken("t4b", 8'h96);
    check("t4_full_word", 32'(exp_q.size()), 32'(W));
    repeat (9) step("t4_bits");

    // Asynchronous reset in the middle of a word
    offer_until_taken("t5", 8'hFF);
    repeat (4) step("t5_bits");
    #2 rst = 1'b0;
    #1 check("t5_async_rst", 32'(dut_outs()), 32'h08);
    exp_q.delete();
    @(posedge clk);
    #1 check("t5_held_rst", 32'(dut_outs()), 32'h08);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    offer_until_taken("t5b", 8'h01);
    repeat (9) step("t5b_bits");

    // Random traffic; upstream holds its word until accepted
    up_valid = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (!up_valid || last_acc) begin
        up_valid = ($urandom_range(0, 2) == 0);
        up_data  = W'($urandom);
      end
      down_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
